simd_status_reg: RTL and testbench

//  Per-lane SIMD status/flag register; parametrised successor of the single-lane status register.

---
 rtl/simd_status_reg.sv | 82 ++++++++
 tb/tb_simd_status_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/simd_status_reg.sv
// Per-lane SIMD status/flag register with overwrite or sticky capture and masked clear.
// It also provides a registered interrupt and a saturating event counter.
module simd_status_reg #(
    parameter int                LANES    = 4,
    parameter int                FLAG_W   = 5,
    parameter int                OUT_W    = 32,
    parameter int                CNT_W    = 8,
    parameter logic [FLAG_W-1:0] IRQ_MASK = {FLAG_W{1'b1}}
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CE,
    input  logic                    MODE,
    input  logic [LANES-1:0]        LANE_EN,
    input  logic [LANES*FLAG_W-1:0] DIN,
    input  logic                    CLR,
    input  logic [FLAG_W-1:0]       CLR_MASK,
    input  logic                    CNT_CLR,
    output logic [OUT_W-1:0]        OUT,
    output logic [FLAG_W-1:0]       SUMMARY,
    output logic                    IRQ,
    output logic [CNT_W-1:0]        EVT_CNT
);

    localparam int F_W = LANES * FLAG_W;

    logic [F_W-1:0]    flags;
    logic [F_W-1:0]    flags_next;
    logic              irq_next;
    logic              evt;
    logic [FLAG_W-1:0] clr_vec;

    always_comb begin
        clr_vec    = CLR ? CLR_MASK : '0;
        flags_next = flags;
        irq_next   = 1'b0;
        evt        = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            // In sticky mode a flag set in the same cycle survives the clear.
            if (CE && LANE_EN[i]) begin
                if (MODE)
                    flags_next[i*FLAG_W +: FLAG_W] = (flags[i*FLAG_W +: FLAG_W] & ~clr_vec)
                                                     | DIN[i*FLAG_W +: FLAG_W];
                else
                    flags_next[i*FLAG_W +: FLAG_W] = DIN[i*FLAG_W +: FLAG_W];
                if (DIN[i*FLAG_W +: FLAG_W] != '0)
                    evt = 1'b1;
            end else begin
                flags_next[i*FLAG_W +: FLAG_W] = flags[i*FLAG_W +: FLAG_W] & ~clr_vec;
            end
            if ((flags[i*FLAG_W +: FLAG_W] & IRQ_MASK) != '0)
                irq_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags   <= '0;
            IRQ     <= 1'b0;
            EVT_CNT <= '0;
        end else begin
            flags <= flags_next;
            IRQ   <= irq_next;
            if (CNT_CLR)
                EVT_CNT <= '0;
            else if (evt && (EVT_CNT != {CNT_W{1'b1}}))
                EVT_CNT <= EVT_CNT + CNT_W'(1);
        end
    end

    always_comb begin
        OUT          = '0;
        OUT[F_W-1:0] = flags;
    end

    always_comb begin
        SUMMARY = '0;
        for (int i = 0; i < LANES; i++)
            SUMMARY = SUMMARY | flags[i*FLAG_W +: FLAG_W];
    end

endmodule

// File: tb/tb_simd_status_reg.sv
// Directed bench for simd_status_reg: a behavioural model checked on every cycle,
// plus literal expectations at the key points of each scenario.
module tb_simd_status_reg;

    localparam int LANES  = 4;
    localparam int FLAG_W = 5;
    localparam int OUT_W  = 32;
    localparam int CNT_W  = 8;
    localparam logic [FLAG_W-1:0] IMASK = 5'b11111;

    logic                    CLK = 1'b0;
    logic                    RESET, CE, MODE, CLR, CNT_CLR;
    logic [LANES-1:0]        LANE_EN;
    logic [LANES*FLAG_W-1:0] DIN;
    logic [FLAG_W-1:0]       CLR_MASK;
    logic [OUT_W-1:0]        OUT;
    logic [FLAG_W-1:0]       SUMMARY;
    logic                    IRQ;
    logic [CNT_W-1:0]        EVT_CNT;

    int checks = 0;
    int passes = 0;

    // Model state: flags as an array of lanes, plain integer counter.
    logic [FLAG_W-1:0] m_f [LANES];
    logic              m_irq = 1'b0;
    int                m_cnt = 0;

    always #5 CLK = ~CLK;

    simd_status_reg #(
        .LANES(LANES), .FLAG_W(FLAG_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .IRQ_MASK(IMASK)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .MODE(MODE), .LANE_EN(LANE_EN), .DIN(DIN),
        .CLR(CLR), .CLR_MASK(CLR_MASK), .CNT_CLR(CNT_CLR), .OUT(OUT), .SUMMARY(SUMMARY),
        .IRQ(IRQ), .EVT_CNT(EVT_CNT)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [FLAG_W-1:0] din_lane(input int i);
        logic [LANES*FLAG_W-1:0] d;
        d = DIN;
        return d[i*FLAG_W +: FLAG_W];
    endfunction

    function automatic logic [FLAG_W-1:0] lane(input int i);
        logic [OUT_W-1:0] o;
        o = OUT;
        return o[i*FLAG_W +: FLAG_W];
    endfunction

    task automatic model_update();
        logic       new_irq;
        logic       evt;
        logic [FLAG_W-1:0] c;
        if (RESET) begin
            for (int i = 0; i < LANES; i++) m_f[i] = '0;
            m_irq = 1'b0;
            m_cnt = 0;
            return;
        end
        new_irq = 1'b0;
        evt     = 1'b0;
        c       = CLR ? CLR_MASK : '0;
        for (int i = 0; i < LANES; i++) begin
            if ((m_f[i] & IMASK) != 0) new_irq = 1'b1;
            if (CE && LANE_EN[i]) begin
                if (din_lane(i) != 0) evt = 1'b1;
                m_f[i] = MODE ? ((m_f[i] & ~c) | din_lane(i)) : din_lane(i);
            end else begin
                m_f[i] = m_f[i] & ~c;
            end
        end
        m_irq = new_irq;
        if (CNT_CLR) m_cnt = 0;
        else if (evt) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    endtask

    task automatic compare_model();
        logic [OUT_W-1:0]  exp_out;
        logic [FLAG_W-1:0] exp_sum;
        exp_out = '0;
        exp_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            exp_out = exp_out | (OUT_W'(m_f[i]) << (i * FLAG_W));
            exp_sum = exp_sum | m_f[i];
        end
        chk("model_out", 64'(OUT), 64'(exp_out));
        chk("model_summary", 64'(SUMMARY), 64'(exp_sum));
        chk("model_irq", 64'(IRQ), 64'(m_irq));
        chk("model_evt_cnt", 64'(EVT_CNT), 64'(m_cnt));
    endtask

    // One clock: model advances on the edge, outputs sampled 1ns later.
    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic idle();
        CE = 0; CLR = 0; CNT_CLR = 0; RESET = 0;
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) m_f[i] = '0;
        RESET = 1; CE = 1; MODE = 0; LANE_EN = '1; DIN = '1;
        CLR = 0; CLR_MASK = '0; CNT_CLR = 0;

        // Reset with capture requested
        tick(); tick();
        chk("reset_out", 64'(OUT), 64'h0);
        chk("reset_irq", 64'(IRQ), 64'h0);
        chk("reset_cnt", 64'(EVT_CNT), 64'h0);

        // Overwrite on lanes 0 and 2
        RESET = 0; CE = 1; MODE = 0; LANE_EN = 4'b0101; DIN = 20'hABCDE;
        tick();
        chk("ovw_lane0", 64'(lane(0)), 64'h1E);
        chk("ovw_lane1", 64'(lane(1)), 64'h00);
        chk("ovw_lane2", 64'(lane(2)), 64'h0F);
        chk("ovw_lane3", 64'(lane(3)), 64'h00);
        chk("ovw_cnt", 64'(EVT_CNT), 64'h1);
        chk("ovw_irq_lag", 64'(IRQ), 64'h0);
        idle();
        tick();
        chk("ovw_irq", 64'(IRQ), 64'h1);

        // Clear everything, then sticky accumulate on lane 0
        CLR = 1; CLR_MASK = 5'h1F; CNT_CLR = 1;
        tick();
        idle();
        tick();
        chk("clr_irq_low", 64'(IRQ), 64'h0);
        CE = 1; MODE = 1; LANE_EN = '1; DIN = 20'h00001;
        tick();
        chk("sticky_irq_lag", 64'(IRQ), 64'h0);
        DIN = 20'h00004;
        tick();
        chk("sticky_lane0", 64'(lane(0)), 64'h05);
        chk("sticky_cnt", 64'(EVT_CNT), 64'h2);
        chk("sticky_irq", 64'(IRQ), 64'h1);

        // Set/clear collision, then clear alone
        DIN = 20'h00001; CLR = 1; CLR_MASK = 5'h1F;
        tick();
        chk("collide_lane0", 64'(lane(0)), 64'h01);
        CE = 0;
        tick();
        chk("clr_lane0", 64'(lane(0)), 64'h00);
        chk("clr_irq_hold", 64'(IRQ), 64'h1);
        idle();
        tick();
        chk("clr_irq_fall", 64'(IRQ), 64'h0);

        // Saturation of the event counter
        CE = 1; MODE = 0; LANE_EN = '1; DIN = 20'h00001;
        for (int n = 0; n < 300; n++) tick();
        chk("sat_cnt", 64'(EVT_CNT), 64'hFF);
        CNT_CLR = 1;
        tick();
        chk("cntclr_wins", 64'(EVT_CNT), 64'h0);
        CNT_CLR = 0;

        // MODE toggles while CE is low are ignored
        CE = 0; MODE = 1; tick(); MODE = 0; tick();

        // Mid-accumulation reset
        CE = 1; MODE = 1; DIN = 20'h21084; tick();
        DIN = 20'h42108; tick();
        RESET = 1; DIN = '1; tick();
        chk("midrst_out", 64'(OUT), 64'h0);
        chk("midrst_sum", 64'(SUMMARY), 64'h0);
        chk("midrst_irq", 64'(IRQ), 64'h0);
        chk("midrst_cnt", 64'(EVT_CNT), 64'h0);
        RESET = 0; DIN = 20'h80000;
        tick();
        chk("resume_out", 64'(OUT), 64'h0008_0000);

        // Disabled lane holds; overwrite beats clear on the enabled lane
        MODE = 0; LANE_EN = 4'b0001; DIN = '1;
        tick();
        chk("hold_lane3", 64'(lane(3)), 64'h10);
        chk("hold_lane0", 64'(lane(0)), 64'h1F);
        CLR = 1; CLR_MASK = 5'h1F; DIN = 20'h00003;
        tick();
        chk("ovw_clr_lane0", 64'(lane(0)), 64'h03);
        chk("ovw_clr_lane3", 64'(lane(3)), 64'h00);
        idle();
        tick(); tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
